ram4x4_arb: RTL and testbench
=============================

# ram4x4_arb

Two-requester round-robin arbiter and access sequencer for the 4-word x 4-bit single-port synchronous RAM (`ram4x4`). It accepts read/write commands from two independent clients (A and B) and serialises them onto the RAM's `we`/`addr`/`data_in` port. Read data comes back from the RAM's registered `data_out` and is routed to the owning client with a one-cycle valid strobe. It sits between the RAM instance and its clients inside the memory subsystem.

## Interface
- `ADDR_W`, 2, RAM address width (4 words)
- `DATA_W`, 4, RAM data width
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_a` / `req_b`  in  1  client command request; held with command fields until granted
- `we_a` / `we_b`  in  1  1 = write, 0 = read
- `addr_a` / `addr_b`  in  ADDR_W  command address
- `wdata_a` / `wdata_b`  in  DATA_W  write data
- `gnt_a` / `gnt_b`  out  1  one-cycle pulse: command accepted and driven to RAM this cycle
- `rvalid_a` / `rvalid_b`  out  1  one-cycle pulse: read data valid on `rdata`
- `rdata`  out  DATA_W  read data, shared by both clients; wired from `ram_dout`
- `ram_we`  out  1  to RAM `we`
- `ram_addr`  out  ADDR_W  to RAM `addr`
- `ram_din`  out  DATA_W  to RAM `data_in`
- `ram_dout`  in  DATA_W  from RAM `data_out`; registered, 1-cycle read latency
- `conflict_cnt`  out  8  contention statistic (see Configuration)

## Operation
- FSM has two states: IDLE (arbitrate) and ISSUE (drive RAM).
- IDLE: if neither request is high, stay in IDLE. Otherwise, latch the winner's we/addr/wdata into the command register and the winner's id into `owner`, then go to ISSUE.
- Arbitration: a single request wins. If both requests are high, the client that is not `last_owner` wins. `last_owner` updates to the winner on every grant. After reset `last_owner` = B, so A wins the first tie.
- ISSUE: `ram_we`/`ram_addr`/`ram_din` are driven from the command register. `gnt_<owner>` is 1. Next state is IDLE unconditionally.
- In all non-ISSUE cycles, `ram_we` = 0, and `ram_addr`/`ram_din` hold their last values.
- Read response: `rvalid_<owner>` is registered high in the cycle after ISSUE when the issued command was a read. Writes produce no `rvalid`; `gnt` is their only acknowledgement.
- Clients may change their command fields in the cycle after they see `gnt`. The IDLE cycle that follows ISSUE samples the next request.
- A write followed by a read to the same address from any client returns the new data; the two are always separated by at least one cycle.
- Reset (at any time, including mid-ISSUE):
  - FSM goes to IDLE.
  - All `gnt`/`rvalid` outputs and `ram_we` are 0.
  - `ram_addr`, `ram_din` and the command register are 0.
  - `last_owner` = B; `conflict_cnt` = 0.
  - Any outstanding read response is discarded and no `rvalid` is emitted.

## Timing
- Request high in IDLE cycle N -> `gnt` and RAM write/read strobe in N+1 -> `rvalid` and `rdata` valid in N+2.
- Peak throughput is one access per 2 cycles. A client holding `req` continuously is granted every other cycle when uncontended, and every fourth cycle when both clients contend.
- `rvalid` for access k and the IDLE arbitration for access k+1 occur in the same cycle.
- All outputs are registered except `rdata`, which is a pass-through of `ram_dout`.

## Configuration
- `RAM4X4_ARB_STATS_EN` defined:
  - `conflict_cnt` increments in every IDLE cycle in which `req_a` and `req_b` are both high.
  - It saturates at 255 and clears only on reset.
- `RAM4X4_ARB_STATS_EN` undefined: `conflict_cnt` is tied to 0 and no counter logic is built.

## Structure
- Package `ram4x4_arb_pkg` holds:
  - `ADDR_W` and `DATA_W` constants
  - the `state_t` enum (IDLE, ISSUE)
  - the `client_t` enum (CLIENT_A, CLIENT_B)
  - the `cmd_t` struct (we, addr, wdata)
- Sub-module `rr_arb2` is a combinational 2-way round-robin pick. Inputs: `req_a`, `req_b`, `last_owner`. Outputs: `any`, `winner`. The FSM, command register, response logic and counter stay in the top module.
- The RAM is not instantiated inside this block; the integration level connects `ram_*` to `ram4x4`.

## Test plan
- Reset: assert `rst` mid-stream -> all `gnt`, `rvalid`, `ram_we` and `conflict_cnt` are 0 immediately. FSM is in IDLE after release.
- A write then read:
  - A writes addr 2 = 0xA -> `gnt_a` with `ram_we`=1, `ram_addr`=2, `ram_din`=0xA.
  - A then reads addr 2 -> `rvalid_a` 2 cycles after the read request, with `rdata`=0xA and `rvalid_b`=0.
- Tie after reset: both request reads (A addr 0, B addr 1) held -> grant order A, B, A, B, each `gnt` 2 cycles apart. Each `rvalid` goes only to its owner, with the data at its address.
- Single streaming client: B holds `req` for 3 reads -> `gnt_b` in cycles 1, 3, 5 and `rvalid_b` in cycles 2, 4, 6.
- Reset during ISSUE of a read -> no `rvalid` follows. The next post-reset tie goes to A.
- With `RAM4X4_ARB_STATS_EN`:
  - both requests held for 600 cycles -> `conflict_cnt` = 255, saturated.
  - Without the macro -> `conflict_cnt` stays 0.

Source files
------------

// File: rtl/ram4x4_arb_pkg.sv
// Shared widths, FSM/client encodings and command record for the ram4x4 arbiter.
package ram4x4_arb_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ram4x4_arb_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the client that did not win last time wins.
module rr_arb2
  import ram4x4_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_owner,
  output logic any,
  output logic winner
);

  always_comb begin
    any = req_a | req_b;
    if (req_a && req_b) begin
      winner = (last_owner == CLIENT_A) ? CLIENT_B : CLIENT_A;
    end else if (req_a) begin
      winner = CLIENT_A;
    end else begin
      winner = CLIENT_B;
    end
  end

endmodule

// File: rtl/ram4x4_arb.sv
// Two-client arbiter/sequencer for the 4x4 single-port RAM.
// Optional contention counter built only when RAM4X4_ARB_STATS_EN is defined.
module ram4x4_arb
  import ram4x4_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [7:0]        conflict_cnt
);

  state_t  state_q;
  client_t owner_q, last_owner_q;
  cmd_t    cmd_q, win_cmd;
  logic    gnt_a_q, gnt_b_q, rvalid_a_q, rvalid_b_q, ram_we_q;
  logic    any, winner_raw;
  client_t winner;

  rr_arb2 u_arb (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_owner (last_owner_q),
    .any        (any),
    .winner     (winner_raw)
  );

  assign winner = client_t'(winner_raw);

  always_comb begin
    if (winner == CLIENT_A) begin
      win_cmd.we    = we_a;
      win_cmd.addr  = addr_a;
      win_cmd.wdata = wdata_a;
    end else begin
      win_cmd.we    = we_b;
      win_cmd.addr  = addr_b;
      win_cmd.wdata = wdata_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= CLIENT_A;
      last_owner_q <= CLIENT_B;
      cmd_q        <= '0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      ram_we_q     <= 1'b0;
    end else begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      ram_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any) begin
            state_q      <= ISSUE;
            cmd_q        <= win_cmd;
            owner_q      <= winner;
            last_owner_q <= winner;
            ram_we_q     <= win_cmd.we;
            gnt_a_q      <= (winner == CLIENT_A);
            gnt_b_q      <= (winner == CLIENT_B);
          end
        end
        ISSUE: begin
          state_q <= IDLE;
          // RAM data_out is registered, so the response lands in the following IDLE cycle
          rvalid_a_q <= !cmd_q.we && (owner_q == CLIENT_A);
          rvalid_b_q <= !cmd_q.we && (owner_q == CLIENT_B);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign ram_we   = ram_we_q;
  // Command register only changes on a grant, so it also holds the RAM port between accesses
  assign ram_addr = cmd_q.addr;
  assign ram_din  = cmd_q.wdata;
  assign rdata    = ram_dout;

`ifdef RAM4X4_ARB_STATS_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && req_a && req_b && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_ram4x4_arb.sv
// Self-checking bench for ram4x4_arb: directed scenarios plus random traffic vs a transaction model.
`timescale 1ns/1ps
module tb_ram4x4_arb;
  import ram4x4_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, we_a, we_b;
  logic [1:0] addr_a, addr_b;
  logic [3:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we;
  logic [3:0] rdata, ram_din, ram_dout;
  logic [1:0] ram_addr;
  logic [7:0] conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram4x4_arb dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .conflict_cnt(conflict_cnt)
  );

  // Behavioural ram4x4: registered read, write on we
  logic [3:0] ram_mem [4];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  // Transaction-level reference: who gets served, what the RAM holds, what comes back
  logic       m_busy, m_owner, m_last, m_we;
  logic [1:0] m_addr;
  logic [3:0] m_wdata, m_undo;
  logic [3:0] m_mem [4];
  logic       e_gnt_a, e_gnt_b, e_rv_a, e_rv_b, e_we;
  logic [1:0] e_addr;
  logic [3:0] e_din, e_rdata;
  int         e_cnt;

  task automatic model_reset();
    if (m_busy && m_we) m_mem[m_addr] = m_undo;
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_we = 1'b0;
    m_addr = '0; m_wdata = '0;
    e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0; e_we = 0;
    e_addr = '0; e_din = '0; e_cnt = 0;
  endtask

  task automatic model_step();
    logic w;
    e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0; e_we = 0;
    if (m_busy) begin
      m_busy = 1'b0;
      if (!m_we) begin
        e_rdata = m_mem[m_addr];
        if (m_owner) e_rv_b = 1; else e_rv_a = 1;
      end
    end else if (req_a || req_b) begin
      if (req_a && req_b) begin
        w = ~m_last;
`ifdef RAM4X4_ARB_STATS_EN
        if (e_cnt < 255) e_cnt++;
`endif
      end else begin
        w = req_b;
      end
      m_owner = w; m_last = w;
      m_we    = w ? we_b : we_a;
      m_addr  = w ? addr_b : addr_a;
      m_wdata = w ? wdata_b : wdata_a;
      if (m_we) begin
        m_undo = m_mem[m_addr];
        m_mem[m_addr] = m_wdata;
      end
      m_busy = 1'b1;
      e_we = m_we; e_addr = m_addr; e_din = m_wdata;
      e_gnt_a = !w; e_gnt_b = w;
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge
  task automatic tick();
    if (rst) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    m_busy = 1'b0;
    model_reset();
    tick(); tick();
    n_cmp++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes got %b exp 00000", {gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we});
    end
    n_cmp++;
    if ({ram_addr, ram_din} !== 6'b0) begin
      n_err++; $display("FAIL reset_ram_port got %h/%h exp 0/0", ram_addr, ram_din);
    end
    n_cmp++;
    if (conflict_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) begin
      logic [3:0] d;
      d = (i == 2) ? 4'hA : 4'($urandom_range(0, 15));
      req_a = 1; we_a = 1; addr_a = 2'(i); wdata_a = d;
      tick();
      n_cmp++;
      if ({gnt_a, gnt_b, ram_we, ram_addr, ram_din} !== {3'b101, 2'(i), d}) begin
        n_err++;
        $display("FAIL wr_issue[%0d] got gnt=%b%b we=%b a=%0d d=%h exp gnt=10 we=1 a=%0d d=%h",
                 i, gnt_a, gnt_b, ram_we, ram_addr, ram_din, i, d);
      end
      req_a = 0;
      tick();
    end
    req_a = 1; we_a = 0; addr_a = 2'd2;
    tick();
    n_cmp++;
    if ({gnt_a, ram_we, ram_addr} !== 4'b1010) begin
      n_err++; $display("FAIL rd_issue got gnt_a=%b we=%b a=%0d exp 1 0 2", gnt_a, ram_we, ram_addr);
    end
    req_a = 0;
    tick();
    n_cmp++;
    if ({rvalid_a, rvalid_b, rdata} !== {2'b10, 4'hA}) begin
      n_err++; $display("FAIL rd_resp got rv=%b%b rdata=%h exp rv=10 rdata=a", rvalid_a, rvalid_b, rdata);
    end
  endtask

  task automatic test_tie();
    logic [3:0] exp_v;
    rst = 1; #1; model_reset(); tick(); rst = 0;
    req_a = 1; we_a = 0; addr_a = 2'd0;
    req_b = 1; we_b = 0; addr_b = 2'd1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_v = {(t % 4 == 1), (t % 4 == 3), (t % 4 == 2), (t % 4 == 0)};
      if (t == 8) begin req_a = 0; req_b = 0; end
      n_cmp++;
      if ({gnt_a, gnt_b, rvalid_a, rvalid_b} !== exp_v) begin
        n_err++; $display("FAIL tie_seq t=%0d got %b exp %b", t, {gnt_a, gnt_b, rvalid_a, rvalid_b}, exp_v);
      end
      if (t % 2 == 0) begin
        n_cmp++;
        if (rdata !== m_mem[(t % 4 == 2) ? 0 : 1]) begin
          n_err++; $display("FAIL tie_rdata t=%0d got %h exp %h", t, rdata, m_mem[(t % 4 == 2) ? 0 : 1]);
        end
      end
    end
    tick();
  endtask

  task automatic test_stream();
    logic [1:0] addrs [3];
    for (int k = 0; k < 3; k++) addrs[k] = 2'($urandom_range(0, 3));
    req_b = 1; we_b = 0; addr_b = addrs[0];
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_cmp++;
      if ({gnt_a, gnt_b, rvalid_a, rvalid_b} !== {1'b0, t % 2 == 1, 1'b0, t % 2 == 0}) begin
        n_err++; $display("FAIL stream t=%0d got %b", t, {gnt_a, gnt_b, rvalid_a, rvalid_b});
      end
      if (t % 2 == 0) begin
        n_cmp++;
        if (rdata !== m_mem[addrs[t/2-1]]) begin
          n_err++; $display("FAIL stream_rdata t=%0d got %h exp %h", t, rdata, m_mem[addrs[t/2-1]]);
        end
      end else if (t < 5) begin
        addr_b = addrs[(t+1)/2];
      end else begin
        req_b = 0;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick();
      n_cmp++;
      if ({gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we, ram_addr, ram_din} !==
          {e_gnt_a, e_gnt_b, e_rv_a, e_rv_b, e_we, e_addr, e_din}) begin
        n_err++;
        $display("FAIL rnd_outputs cyc %0d got %b exp %b", i,
                 {gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we, ram_addr, ram_din},
                 {e_gnt_a, e_gnt_b, e_rv_a, e_rv_b, e_we, e_addr, e_din});
      end
      if (e_rv_a || e_rv_b) begin
        n_cmp++;
        if (rdata !== e_rdata) begin
          n_err++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", i, rdata, e_rdata);
        end
      end
      n_cmp++;
      if (conflict_cnt !== e_cnt[7:0]) begin
        n_err++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, conflict_cnt, e_cnt);
      end
      // Clients keep a command until granted, then issue a new one or go quiet
      if (e_gnt_a || !req_a) begin
        req_a = ($urandom_range(0, 2) != 0);
        we_a = 1'($urandom); addr_a = 2'($urandom); wdata_a = 4'($urandom);
      end
      if (e_gnt_b || !req_b) begin
        req_b = ($urandom_range(0, 2) != 0);
        we_b = 1'($urandom); addr_b = 2'($urandom); wdata_b = 4'($urandom);
      end
    end
    req_a = 0; req_b = 0;
    tick(); tick();
  endtask

  task automatic test_stats();
    req_a = 1; we_a = 0; addr_a = 2'($urandom);
    req_b = 1; we_b = 0; addr_b = 2'($urandom);
    for (int t = 0; t < 600; t++) begin
      tick();
      if (t == 20) begin
        n_cmp++;
        if (conflict_cnt !== e_cnt[7:0]) begin
          n_err++; $display("FAIL stats_mid got %0d exp %0d", conflict_cnt, e_cnt);
        end
      end
    end
    n_cmp++;
`ifdef RAM4X4_ARB_STATS_EN
    if (conflict_cnt !== 8'd255) begin
      n_err++; $display("FAIL stats_sat got %0d exp 255", conflict_cnt);
    end
`else
    if (conflict_cnt !== 8'd0) begin
      n_err++; $display("FAIL stats_off got %0d exp 0", conflict_cnt);
    end
`endif
    req_a = 0; req_b = 0;
    tick(); tick();
  endtask

  task automatic test_reset_issue();
    req_a = 1; we_a = 0; addr_a = 2'd3;
    tick();
    n_cmp++;
    if (gnt_a !== 1'b1) begin
      n_err++; $display("FAIL rst_iss_gnt got %b exp 1", gnt_a);
    end
    req_a = 0;
    rst = 1; #1; model_reset();
    n_cmp++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we, ram_addr, ram_din, conflict_cnt} !== 19'b0) begin
      n_err++;
      $display("FAIL rst_async got strobes=%b a=%0d d=%h cnt=%0d exp all 0",
               {gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we}, ram_addr, ram_din, conflict_cnt);
    end
    tick();
    rst = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_cmp++;
      if ({rvalid_a, rvalid_b} !== 2'b00) begin
        n_err++; $display("FAIL rst_no_rvalid t=%0d got %b%b exp 00", t, rvalid_a, rvalid_b);
      end
    end
    req_a = 1; req_b = 1; we_a = 0; we_b = 0;
    tick();
    n_cmp++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      n_err++; $display("FAIL rst_tie got %b%b exp 10", gnt_a, gnt_b);
    end
    req_a = 0; req_b = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_stream();
    test_random();
    test_stats();
    test_reset_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
